// File: rtl/scanline_span_setup_if.sv
// scanline_span_setup_if: request/result bundle between a scanline driver and the span setup engine.
interface scanline_span_setup_if;
  logic start;
  logic signed [28:0] a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v;
  logic [16:0] one_over_y;
  logic busy, done;
  logic signed [32:0] u0, v0, u_stride, v_stride;
  modport master (
    output start, a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v, one_over_y,
    input  busy, done, u0, v0, u_stride, v_stride
  );
  modport slave (
    input  start, a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v, one_over_y,
    output busy, done, u0, v0, u_stride, v_stride
  );
endinterface

// File: rtl/scanline_span_setup.sv
// scanline_span_setup: per-scanline texture start/stride setup using one shared 17-cycle shift-add multiplier.
module scanline_span_setup #(
  parameter int FRAC       = 16,
  parameter int SPAN_RECIP = 102
) (
  input logic clk,
  input logic resetn,
  scanline_span_setup_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;
  state_t state, state_nxt;
  logic signed [28:0] s_au, s_av, s_bu, s_bv, s_cu, s_cv, s_du, s_dv;
  logic [16:0] s_oy;
  logic signed [32:0] lu, lv, ru, rv, su;
  logic signed [51:0] acc, mc, prod, op_mc, pshift;
  logic [16:0] mr, op_mr;
  logic [4:0] cnt;
  logic [2:0] idx, sel;
  logic signed [28:0] ea, ec, ecur;
  logic signed [29:0] de;
  logic signed [33:0] ds;
  logic signed [32:0] esum, sval;
  logic step_end, last;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    step_end  = state == MUL && cnt == 5'd16;
    last      = step_end && idx == 3'd5;
    state_nxt = state == IDLE ? (bus.start ? LOAD : IDLE) :
                state == LOAD ? MUL :
                state == MUL  ? (last ? DONE : MUL) : IDLE;
  end
  always_comb begin
    bus.busy = state == LOAD || state == MUL;
    bus.done = state == DONE;
  end
  // Operands for the next product are selected while the current one finishes.
  always_comb begin
    sel    = state == LOAD ? 3'd0 : idx + 3'd1;
    ea     = sel == 3'd0 ? s_au : sel == 3'd1 ? s_av : sel == 3'd2 ? s_bu : s_bv;
    ec     = sel == 3'd0 ? s_cu : sel == 3'd1 ? s_cv : sel == 3'd2 ? s_du : s_dv;
    de     = 30'(ea) - 30'(ec);
    ds     = sel == 3'd4 ? 34'(ru) - 34'(lu) : 34'(rv) - 34'(lv);
    op_mc  = sel < 3'd4 ? 52'(de >>> FRAC) : 52'(ds);
    op_mr  = sel < 3'd4 ? s_oy : 17'(SPAN_RECIP);
    prod   = acc + (mr[0] ? mc : 52'sd0);
    ecur   = idx == 3'd0 ? s_cu : idx == 3'd1 ? s_cv : idx == 3'd2 ? s_du : s_dv;
    esum   = 33'(ecur) + 33'($signed(prod[30:0]));
    pshift = prod >>> FRAC;
    sval   = pshift[32:0];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {s_au, s_av, s_bu, s_bv, s_cu, s_cv, s_du, s_dv} <= '0;
      s_oy <= '0;
      {lu, lv, ru, rv, su} <= '0;
      acc <= '0;
      mc <= '0;
      mr <= '0;
      cnt <= '0;
      idx <= '0;
      bus.u0 <= '0;
      bus.v0 <= '0;
      bus.u_stride <= '0;
      bus.v_stride <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        {s_au, s_av, s_bu, s_bv} <= {bus.a_u, bus.a_v, bus.b_u, bus.b_v};
        {s_cu, s_cv, s_du, s_dv} <= {bus.c_u, bus.c_v, bus.d_u, bus.d_v};
        s_oy <= bus.one_over_y;
      end
      if (state == LOAD || step_end) begin
        mc <= op_mc;
        mr <= op_mr;
        acc <= '0;
        cnt <= '0;
      end else if (state == MUL) begin
        acc <= prod;
        mc <= mc <<< 1;
        mr <= mr >> 1;
        cnt <= cnt + 5'd1;
      end
      if (state == LOAD) idx <= '0;
      else if (step_end) idx <= idx + 3'd1;
      if (step_end) begin
        if (idx == 3'd0) lu <= esum;
        if (idx == 3'd1) lv <= esum;
        if (idx == 3'd2) ru <= esum;
        if (idx == 3'd3) rv <= esum;
        if (idx == 3'd4) su <= sval;
        if (idx == 3'd5) begin
          bus.u0 <= lu;
          bus.v0 <= lv;
          bus.u_stride <= su;
          bus.v_stride <= sval;
        end
      end
    end
endmodule

// File: tb/tb_scanline_span_setup.sv
// tb_scanline_span_setup: scoreboard bench comparing span results and latency against a reference formula.
module tb_scanline_span_setup;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {
    logic signed [32:0] u0, v0, us, vs;
    int cyc;
  } exp_t;
  exp_t q[$];
  scanline_span_setup_if bus();
  scanline_span_setup #(.FRAC(16), .SPAN_RECIP(102)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic logic signed [32:0] edge_m(input longint a, input longint c, input longint oy);
    return 33'(c + ((a - c) >>> 16) * oy);
  endfunction
  function automatic logic signed [32:0] stride_m(input longint l, input longint r);
    return 33'(((r - l) * 102) >>> 16);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.done) begin
      if (q.size() == 0) check("spurious_done", bus.done, 0);
      else begin
        e = q.pop_front();
        check("latency", cyc - e.cyc, 103);
        check("u0", bus.u0, e.u0);
        check("v0", bus.v0, e.v0);
        check("u_stride", bus.u_stride, e.us);
        check("v_stride", bus.v_stride, e.vs);
      end
    end
  end
  task automatic set_in(input longint au, av, bu, bv, cu, cv, du, dv, oy);
    bus.a_u = 29'(au); bus.a_v = 29'(av); bus.b_u = 29'(bu); bus.b_v = 29'(bv);
    bus.c_u = 29'(cu); bus.c_v = 29'(cv); bus.d_u = 29'(du); bus.d_v = 29'(dv);
    bus.one_over_y = 17'(oy);
  endtask
  task automatic go(input longint au, av, bu, bv, cu, cv, du, dv, oy);
    exp_t e;
    logic signed [32:0] lu, lv, ru, rv;
    @(negedge clk);
    set_in(au, av, bu, bv, cu, cv, du, dv, oy);
    lu = edge_m(longint'(bus.a_u), longint'(bus.c_u), longint'(bus.one_over_y));
    lv = edge_m(longint'(bus.a_v), longint'(bus.c_v), longint'(bus.one_over_y));
    ru = edge_m(longint'(bus.b_u), longint'(bus.d_u), longint'(bus.one_over_y));
    rv = edge_m(longint'(bus.b_v), longint'(bus.d_v), longint'(bus.one_over_y));
    e.u0 = lu;
    e.v0 = lv;
    e.us = stride_m(longint'(lu), longint'(ru));
    e.vs = stride_m(longint'(lv), longint'(rv));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    q.push_back(e);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("run_completed", q.size(), 0);
  endtask
  function automatic longint rnd();
    logic signed [28:0] r;
    r = 29'($urandom);
    return longint'(r);
  endfunction
  initial begin
    bus.start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_u0", bus.u0, 0);
    check("rst_v0", bus.v0, 0);
    check("rst_u_stride", bus.u_stride, 0);
    check("rst_v_stride", bus.v_stride, 0);
    resetn = 1'b1;
    go(655360, 0, 1310720, 0, 655360, 0, 1310720, 0, 32768);
    wait_done();
    go(262144, 0, 262144, 0, 0, 0, 262144, 0, 32768);
    wait_done();
    go(0, 0, 262144, 0, 262144, 0, 262144, 0, 32768);
    wait_done();
    go(655360, 0, 0, 0, 655360, 0, 0, 0, 32768);
    wait_done();
    go(-1000000, 655360, 3000000, -655360, 500000, 0, -200000, 1310720, 131071);
    wait_done();
    go(268435455, -268435456, -268435456, 268435455, -268435456, 268435455, 268435455, -268435456, 65536);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      go(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), longint'($urandom_range(0, 131071)));
      wait_done();
    end
    // Re-pulsed start and input changes mid-run must not disturb the snapshot.
    go(1000000, -2000000, 4000000, 3000000, -500000, 100000, 250000, -750000, 40000);
    repeat (20) @(negedge clk);
    set_in(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 12345);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    set_in(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 777);
    wait_done();
    repeat (110) @(negedge clk);
    // A start coincident with done is dropped.
    go(655360, 0, 1310720, 0, 655360, 0, 1310720, 0, 32768);
    for (int n = 0; n < 300 && !bus.done; n++) @(negedge clk);
    check("done_seen", bus.done, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("drop_at_done_busy", bus.busy, 0);
    @(negedge clk);
    check("drop_at_done_idle", bus.busy, 0);
    check("queue_drained", q.size(), 0);
    // Reset mid-run aborts without a done pulse.
    go(262144, 0, 262144, 0, 0, 0, 262144, 0, 32768);
    repeat (50) @(posedge clk);
    #2;
    resetn = 1'b0;
    q.delete();
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_u0", bus.u0, 0);
    check("abort_v0", bus.v0, 0);
    check("abort_u_stride", bus.u_stride, 0);
    check("abort_v_stride", bus.v_stride, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (120) @(negedge clk);
    check("abort_idle_busy", bus.busy, 0);
    go(0, 262144, 262144, 0, 262144, 0, 262144, 655360, 32768);
    wait_done();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scanline_span_setup.md
SCANLINE_SPAN_SETUP -- requirements
Module: scanline_span_setup

Interface
REQ-001 The block SHALL have parameter FRAC, default 16, giving the number of fractional bits of all texture-space coordinates.
REQ-002 The block SHALL have parameter SPAN_RECIP, default 102, giving the unsigned 0.16 value of 1/visible_width (about 65536/640).
REQ-003 The block SHALL have port clk, input, 1 bit: pixel clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to compute the spans for the next scanline.
REQ-006 The block SHALL have ports a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v, input, 29 bits signed each: frustum corner coordinates in texture space.
REQ-007 The block SHALL have port one_over_y, input, 17 bits unsigned: row reciprocal in 0.16 format.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that the results are valid.
REQ-010 The block SHALL have ports u0 and v0, output, 33 bits signed each: texture coordinate at the left edge of the scanline.
REQ-011 The block SHALL have ports u_stride and v_stride, output, 33 bits signed each: per-pixel texture step.

Function
REQ-012 start SHALL be accepted only in state IDLE; start in any other state SHALL be ignored without side effects.
REQ-013 On acceptance, all eight corner inputs and one_over_y SHALL be snapshotted into registers; later input changes SHALL NOT affect the current computation.
REQ-014 The FSM SHALL have states IDLE, LOAD (1 cycle), MUL (6 products x 17 cycles), DONE (1 cycle), and SHALL then return to IDLE.
REQ-015 Products SHALL use one shared shift-add multiplier: signed multiplicand, 17-bit unsigned multiplier, one multiplier bit per cycle, 17 cycles per product.
REQ-016 Products SHALL be computed in this order: left_u, left_v, right_u, right_v, u_stride, v_stride.
REQ-017 Edge terms SHALL be computed as left_u = c_u + (((a_u - c_u) >>> FRAC) * one_over_y), and likewise left_v from (a_v, c_v), right_u from (b_u, d_u), right_v from (b_v, d_v).
REQ-018 Edge arithmetic widths SHALL be: differences 30 bits signed; arithmetic shift; 31-bit product; sum sign-extended to 33 bits.
REQ-019 Strides SHALL be computed as u_stride = ((right_u - left_u) * SPAN_RECIP) >>> FRAC, and likewise v_stride, using a 34-bit difference; the result SHALL be truncated to 33 bits with two's-complement wrap.
REQ-020 u0, v0, u_stride and v_stride SHALL update only in the DONE cycle, and SHALL hold their values otherwise.
REQ-021 done SHALL be high exactly during the DONE cycle, the 104th cycle after the edge at which start was sampled (LOAD=1, MUL=102, DONE=1).
REQ-022 busy SHALL be high during LOAD and MUL, and low in IDLE and DONE.
REQ-023 Total latency SHALL be 104 cycles, which fits within the 160-pixel horizontal blanking interval.
REQ-024 The DONE state SHALL NOT accept start; a start pulse coincident with done SHALL be dropped.

Reset
REQ-025 While resetn=0, the state SHALL be IDLE, and busy, done, u0, v0, u_stride, v_stride and all internal accumulators SHALL be 0.
REQ-026 Reset asserted mid-computation SHALL abort it, with no done pulse after release.
REQ-027 The first start after reset release SHALL be accepted normally.

Verification
REQ-028 Reset scenario: hold resetn=0 for 3 cycles -> all outputs 0, busy=0, done=0.
REQ-029 Constant-edge scenario: a_u=c_u=655360, b_u=d_u=1310720, v corners=0, one_over_y=32768, pulse start -> done exactly 104 cycles later, u0=655360, u_stride=1020, v0=0, v_stride=0.
REQ-030 Interpolation scenario: c_u=0, a_u=262144, b_u=d_u=262144, one_over_y=32768 -> u0=131072, u_stride=(131072*102)>>>16=204.
REQ-031 Negative scenario: c_u=262144, a_u=0, one_over_y=32768 -> u0=131072; separately, left=655360 and right=0 -> u_stride=-1020.
REQ-032 Robustness scenario: start re-pulsed while busy, and corner inputs changed mid-run -> exactly one done, with results from the original snapshot.
REQ-033 Abort scenario: resetn pulsed low at cycle 50 of a run -> busy=0, outputs 0, no done pulse; a following start completes in 104 cycles.
